// File: rtl/poly_io_sequencer.sv
// Word-serial I/O sequencer for the AMNS polynomial register bank: streams operands
// into A/B/M/M_prime_0 and drains RES onto a valid/ready result stream.
//
// state    | meaning
// IDLE     | waiting for start_i
// LOAD_A   | writing N*S words of A
// LOAD_B   | writing N*S words of B
// LOAD_M   | writing N*S words of modulus M
// LOAD_MP  | writing N words of M_prime_0
// WAIT_RES | operands in bank, waiting for datapath res_valid_i
// STORE    | draining N*S RES words onto the result stream
module poly_io_sequencer #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  load_key_i,
  input  logic                  din_valid_i,
  output logic                  din_ready_o,
  input  logic [WORD_WIDTH-1:0] din_i,
  output logic [1:0]            INPUT_reg_sel_o,
  output logic                  INPUT_reg_en_o,
  output logic [WORD_WIDTH-1:0] INPUT_reg_din_o,
  output logic                  operands_loaded_o,
  input  logic                  res_valid_i,
  output logic                  store_RES_reg_en_o,
  input  logic [WORD_WIDTH-1:0] RES_reg_dout_i,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic [WORD_WIDTH-1:0] dout_o,
  output logic                  dout_last_o,
  output logic                  key_loaded_o,
  output logic                  busy_o
);

  localparam int NS = N * S;
  localparam int CW = $clog2(NS + 1);
  localparam logic [CW-1:0] LAST_NS = CW'(NS - 1);
  localparam logic [CW-1:0] LAST_N  = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, LOAD_M, LOAD_MP, WAIT_RES, STORE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            key_mode;
  logic            loading;
  logic            accept;
  logic            cnt_last;

  always_comb begin
    loading            = (state == LOAD_A) || (state == LOAD_B) ||
                         (state == LOAD_M) || (state == LOAD_MP);
    accept             = loading & din_valid_i;
    din_ready_o        = loading;
    INPUT_reg_en_o     = accept;
    INPUT_reg_din_o    = din_i;
    cnt_last           = (state == LOAD_MP) ? (cnt == LAST_N) : (cnt == LAST_NS);
    dout_valid_o       = (state == STORE);
    dout_o             = RES_reg_dout_i;
    store_RES_reg_en_o = (state == STORE) & dout_ready_i;
    dout_last_o        = (state == STORE) & (cnt == LAST_NS);
    busy_o             = (state != IDLE);
    case (state)
      LOAD_B:  INPUT_reg_sel_o = 2'b01;
      LOAD_M:  INPUT_reg_sel_o = 2'b10;
      LOAD_MP: INPUT_reg_sel_o = 2'b11;
      default: INPUT_reg_sel_o = 2'b00;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state             <= IDLE;
      cnt               <= '0;
      key_mode          <= 1'b0;
      key_loaded_o      <= 1'b0;
      operands_loaded_o <= 1'b0;
    end else begin
      operands_loaded_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= LOAD_A;
            // a bank without a valid key always gets a full load
            key_mode <= load_key_i | ~key_loaded_o;
            cnt      <= '0;
          end
        end
        LOAD_A, LOAD_B, LOAD_M, LOAD_MP: begin
          if (accept) begin
            if (cnt_last) begin
              cnt <= '0;
              case (state)
                LOAD_A: state <= LOAD_B;
                LOAD_B: begin
                  if (key_mode) begin
                    state        <= LOAD_M;
                    key_loaded_o <= 1'b0;
                  end else begin
                    state             <= WAIT_RES;
                    operands_loaded_o <= 1'b1;
                  end
                end
                LOAD_M: state <= LOAD_MP;
                default: begin
                  state             <= WAIT_RES;
                  key_loaded_o      <= 1'b1;
                  operands_loaded_o <= 1'b1;
                end
              endcase
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT_RES: begin
          if (res_valid_i) begin
            state <= STORE;
            cnt   <= '0;
          end
        end
        STORE: begin
          if (dout_ready_i) begin
            if (cnt == LAST_NS) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
